// File: rtl/sram_nbt_ctrl.sv
// ---------------------------------------------------------------------------
// sram_nbt_ctrl
//   Two-port round-robin controller for a 36-bit wide synchronous
//   no-bus-turnaround (NBT) SRAM. It issues one command per cycle with no
//   bubbles between reads and writes. It drops the SRAM into ZZ sleep after a
//   configurable idle period and wakes it on demand.
//
//   Optional feature macro: SRAM_PARITY_EN
//     When defined, bit 9k+8 of each written byte lane is replaced by the even
//     parity of bits [9k+7:9k], and rd_perr[k] flags a parity mismatch on the
//     read data. When undefined, data passes through raw and rd_perr is 0.
//
// Ports
//   CK, nRST                 clock (rising edge), synchronous active-low reset
//   pX_req/we/addr/wdata/be  requester X command (held until pX_gnt)
//   pX_gnt                   combinational accept strobe for requester X
//   rd_valid/port/data/perr  read return, one pulse per read, in issue order
//   A, nE1, E2, nE3, nW,
//   nBa..nBd, nG, pADV,
//   nCKE, ZZ                 registered SRAM control pins
//   dq_o, dq_oe, dq_i        split SRAM data bus (DQa = [8:0] .. DQd = [35:27])
// ---------------------------------------------------------------------------
module sram_nbt_ctrl #(
  parameter int A_SIZE      = 21,
  parameter int IDLE_LIMIT  = 64,
  parameter int WAKE_CYCLES = 32
) (
  input  logic              CK,
  input  logic              nRST,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [A_SIZE-1:0] p0_addr,
  input  logic [35:0]       p0_wdata,
  input  logic [3:0]        p0_be,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [A_SIZE-1:0] p1_addr,
  input  logic [35:0]       p1_wdata,
  input  logic [3:0]        p1_be,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              rd_valid,
  output logic              rd_port,
  output logic [35:0]       rd_data,
  output logic [3:0]        rd_perr,
  output logic [A_SIZE-1:0] A,
  output logic              nE1,
  output logic              E2,
  output logic              nE3,
  output logic              nW,
  output logic              nBa,
  output logic              nBb,
  output logic              nBc,
  output logic              nBd,
  output logic              nG,
  output logic              pADV,
  output logic              nCKE,
  output logic              ZZ,
  output logic [35:0]       dq_o,
  output logic              dq_oe,
  input  logic [35:0]       dq_i
);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_SLEEP  = 2'd1;
  localparam logic [1:0] ST_WAKE   = 2'd2;

  // Limits below 4 are raised to 4 so the 3-deep command pipeline has always
  // drained before the SRAM is put to sleep.
  localparam int             IDLE_EFF  = (IDLE_LIMIT < 4) ? 4 : IDLE_LIMIT;
  localparam int             IW        = $clog2(IDLE_EFF + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_EFF - 1);
  localparam bit             SLEEP_EN  = (IDLE_LIMIT > 0);
  localparam int             WAKE_LAST = (WAKE_CYCLES > 1) ? WAKE_CYCLES - 1 : 0;
  localparam int             WW        = $clog2(WAKE_LAST + 2);
  localparam logic [WW-1:0]  WAKE_END  = WW'(WAKE_LAST);

`ifdef SRAM_PARITY_EN
  function automatic logic [35:0] add_parity(input logic [35:0] d);
    logic [35:0] o;
    o = d;
    for (int k = 0; k < 4; k++) o[9*k+8] = ^d[9*k +: 8];
    return o;
  endfunction

  function automatic logic [3:0] parity_err(input logic [35:0] d);
    logic [3:0] e;
    for (int k = 0; k < 4; k++) e[k] = d[9*k+8] ^ (^d[9*k +: 8]);
    return e;
  endfunction
`endif

  logic [1:0]        r_state;
  logic              r_last_p1;
  logic [IW-1:0]     r_idle;
  logic [WW-1:0]     r_wake;
  logic              r_zz;

  logic              w_active;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_busy;
  logic              w_sel_we;
  logic [A_SIZE-1:0] w_sel_addr;
  logic [35:0]       w_sel_wdata;
  logic [3:0]        w_sel_be;
  logic [35:0]       w_wdata;
  logic [3:0]        w_perr;

  logic              r_vld_p1, r_we_p1, r_port_p1;
  logic [35:0]       r_wdata_p1;
  logic              r_vld_p2, r_we_p2, r_port_p2;
  logic [35:0]       r_wdata_p2;
  logic              r_vld_p3, r_we_p3, r_port_p3;

  logic [A_SIZE-1:0] r_A;
  logic              r_nE;
  logic              r_nW;
  logic [3:0]        r_nB;
  logic              r_nG;
  logic              r_dq_oe;
  logic [35:0]       r_dq_o;
  logic              r_rd_valid;
  logic              r_rd_port;
  logic [35:0]       r_rd_data;
  logic [3:0]        r_rd_perr;

  // Round-robin: r_last_p1 = 1 means p1 won last, so p0 wins a tie.
  assign w_active = (r_state == ST_ACTIVE) && nRST;
  assign w_gnt0   = w_active && p0_req && (!p1_req || r_last_p1);
  assign w_gnt1   = w_active && p1_req && (!p0_req || !r_last_p1);
  assign w_acc    = w_gnt0 || w_gnt1;
  assign w_busy   = r_vld_p1 || r_vld_p2 || r_vld_p3;

  always_comb begin
    w_sel_we    = p0_we;
    w_sel_addr  = p0_addr;
    w_sel_wdata = p0_wdata;
    w_sel_be    = p0_be;
    if (w_gnt1) begin
      w_sel_we    = p1_we;
      w_sel_addr  = p1_addr;
      w_sel_wdata = p1_wdata;
      w_sel_be    = p1_be;
    end
  end

`ifdef SRAM_PARITY_EN
  assign w_wdata = add_parity(w_sel_wdata);
  assign w_perr  = parity_err(dq_i);
`else
  assign w_wdata = w_sel_wdata;
  assign w_perr  = 4'b0000;
`endif

  // Power state machine and arbitration history
  always_ff @(posedge CK) begin
    if (!nRST) begin
      r_state   <= ST_ACTIVE;
      r_last_p1 <= 1'b1;
      r_idle    <= '0;
      r_wake    <= '0;
      r_zz      <= 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (w_acc) begin
            r_idle    <= '0;
            r_last_p1 <= w_gnt1;
          end else if (SLEEP_EN) begin
            if (r_idle == IDLE_LAST && !w_busy) begin
              r_state <= ST_SLEEP;
              r_zz    <= 1'b1;
              r_idle  <= '0;
            end else if (r_idle != IDLE_LAST) begin
              r_idle <= r_idle + 1'b1;
            end
          end
        end
        ST_SLEEP: begin
          if (p0_req || p1_req) begin
            r_state <= ST_WAKE;
            r_wake  <= '0;
            r_zz    <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (r_wake == WAKE_END) begin
            r_state <= ST_ACTIVE;
            r_idle  <= '0;
          end else begin
            r_wake <= r_wake + 1'b1;
          end
        end
        default: r_state <= ST_ACTIVE;
      endcase
    end
  end

  // Stage p1: command on the pins (cycle T)
  always_ff @(posedge CK) begin
    if (!nRST) begin
      r_vld_p1 <= 1'b0;
      r_A      <= '0;
      r_nE     <= 1'b1;
      r_nW     <= 1'b1;
      r_nB     <= 4'hF;
    end else begin
      r_vld_p1 <= w_acc;
      if (w_acc) begin
        r_A  <= w_sel_addr;
        r_nE <= 1'b0;
        r_nW <= ~w_sel_we;
        r_nB <= w_sel_we ? ~w_sel_be : 4'h0;
      end else begin
        r_nE <= 1'b1;
        r_nW <= 1'b1;
        r_nB <= 4'hF;
      end
    end
  end

  always_ff @(posedge CK) begin
    r_we_p1    <= w_sel_we;
    r_port_p1  <= w_gnt1;
    r_wdata_p1 <= w_wdata;
    r_we_p2    <= r_we_p1;
    r_port_p2  <= r_port_p1;
    r_wdata_p2 <= r_wdata_p1;
    r_we_p3    <= r_we_p2;
    r_port_p3  <= r_port_p2;
  end

  // Stage p2 (T+1) / p3 (T+2): output enable for writes, nG and capture for reads
  always_ff @(posedge CK) begin
    if (!nRST) begin
      r_vld_p2   <= 1'b0;
      r_vld_p3   <= 1'b0;
      r_nG       <= 1'b1;
      r_dq_oe    <= 1'b0;
      r_dq_o     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_port  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_perr  <= '0;
    end else begin
      r_vld_p2   <= r_vld_p1;
      r_vld_p3   <= r_vld_p2;
      // SRAM drives DQ for a read during T+1 and T+2.
      r_nG       <= ~((r_vld_p1 && !r_we_p1) || (r_vld_p2 && !r_we_p2));
      r_dq_oe    <= r_vld_p2 && r_we_p2;
      if (r_vld_p2 && r_we_p2) r_dq_o <= r_wdata_p2;
      // Stage p3 boundary: read data lands at the end of T+2.
      r_rd_valid <= r_vld_p3 && !r_we_p3;
      if (r_vld_p3 && !r_we_p3) begin
        r_rd_port <= r_port_p3;
        r_rd_data <= dq_i;
        r_rd_perr <= w_perr;
      end
    end
  end

  assign p0_gnt   = w_gnt0;
  assign p1_gnt   = w_gnt1;
  assign rd_valid = r_rd_valid;
  assign rd_port  = r_rd_port;
  assign rd_data  = r_rd_data;
  assign rd_perr  = r_rd_perr;
  assign A        = r_A;
  assign nE1      = r_nE;
  assign E2       = ~r_nE;
  assign nE3      = r_nE;
  assign nW       = r_nW;
  assign nBa      = r_nB[0];
  assign nBb      = r_nB[1];
  assign nBc      = r_nB[2];
  assign nBd      = r_nB[3];
  assign nG       = r_nG;
  assign pADV     = 1'b0;
  assign nCKE     = 1'b0;
  assign ZZ       = r_zz;
  assign dq_o     = r_dq_o;
  assign dq_oe    = r_dq_oe;

endmodule

// File: tb/tb_sram_nbt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_nbt_ctrl
//   Bench for sram_nbt_ctrl with IDLE_LIMIT=8, WAKE_CYCLES=4. A pin-level
//   SRAM model answers reads; a reference memory updated at accept time
//   produces expected read returns that are queued and compared on rd_valid.
// ---------------------------------------------------------------------------
module tb_sram_nbt_ctrl;
  localparam int AW = 21;

  logic          CK = 1'b0;
  logic          nRST;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [35:0]   p0_wdata, p1_wdata;
  logic [3:0]    p0_be, p1_be;
  logic          p0_gnt, p1_gnt;
  logic          rd_valid, rd_port;
  logic [35:0]   rd_data;
  logic [3:0]    rd_perr;
  logic [AW-1:0] A;
  logic          nE1, E2, nE3, nW, nBa, nBb, nBc, nBd, nG, pADV, nCKE, ZZ;
  logic [35:0]   dq_o, dq_i;
  logic          dq_oe;

  always #5 CK = ~CK;

  sram_nbt_ctrl #(.A_SIZE(AW), .IDLE_LIMIT(8), .WAKE_CYCLES(4)) dut (
    .CK(CK), .nRST(nRST),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .rd_valid(rd_valid), .rd_port(rd_port), .rd_data(rd_data), .rd_perr(rd_perr),
    .A(A), .nE1(nE1), .E2(E2), .nE3(nE3), .nW(nW),
    .nBa(nBa), .nBb(nBb), .nBc(nBc), .nBd(nBd),
    .nG(nG), .pADV(pADV), .nCKE(nCKE), .ZZ(ZZ),
    .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [35:0] data;
    logic [3:0]  perr;
  } rd_exp_t;

  typedef struct {
    logic          v;
    logic          we;
    logic [AW-1:0] a;
    logic [3:0]    nb;
  } pin_t;

  rd_exp_t     sb[$];
  logic [35:0] ref_mem[int];
  logic [35:0] sram[int];
  int          flip_addr = -1;
  pin_t        h1, h2;

  function automatic logic [35:0] par_fix(input logic [35:0] d);
    logic [35:0] o;
    o = d;
`ifdef SRAM_PARITY_EN
    for (int k = 0; k < 4; k++) o[9*k+8] = ^d[9*k +: 8];
`endif
    return o;
  endfunction

  // Reference model update at accept time.
  task automatic record(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [35:0] wd, input logic [3:0] be);
    logic [35:0] old, nw, wp;
    rd_exp_t     e;
    old = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 36'h0;
    if (we) begin
      nw = old;
      wp = par_fix(wd);
      for (int k = 0; k < 4; k++) if (be[k]) nw[9*k +: 9] = wp[9*k +: 9];
      ref_mem[int'(addr)] = nw;
    end else begin
      e.port = port;
      e.data = old;
      e.perr = 4'b0000;
      if (int'(addr) == flip_addr) begin
        e.data[8] = ~e.data[8];
`ifdef SRAM_PARITY_EN
        e.perr = 4'b0001;
`endif
      end
      sb.push_back(e);
    end
  endtask

  // Pin-level SRAM model and continuous protocol checks (sampled on negedge).
  always @(negedge CK) begin : sram_model
    pin_t        cur;
    logic [35:0] d, m;
    rd_exp_t     e;
    if (!nRST) begin
      h1.v <= 1'b0;
      h2.v <= 1'b0;
      dq_i <= '0;
      sb.delete();
    end else begin
      cur.v  = !nE1 && E2 && !nE3;
      cur.we = !nW;
      cur.a  = A;
      cur.nb = {nBd, nBc, nBb, nBa};
      check_eq("padv_ncke", {62'd0, pADV, nCKE}, 64'd0);
      check_eq("nG", nG, !((h1.v && !h1.we) || (h2.v && !h2.we)));
      check_eq("dq_oe", dq_oe, h2.v && h2.we);
      if (h2.v && h2.we) begin
        m = sram.exists(int'(h2.a)) ? sram[int'(h2.a)] : 36'h0;
        for (int k = 0; k < 4; k++) if (!h2.nb[k]) m[9*k +: 9] = dq_o[9*k +: 9];
        sram[int'(h2.a)] = m;
      end
      if (h2.v && !h2.we) begin
        d = sram.exists(int'(h2.a)) ? sram[int'(h2.a)] : 36'h0;
        if (int'(h2.a) == flip_addr) d[8] = ~d[8];
        dq_i <= d;
      end else begin
        dq_i <= 36'({$urandom(), $urandom()});
      end
      if (rd_valid) begin
        if (sb.size() == 0) begin
          check_eq("rd_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rd_port", rd_port, e.port);
          check_eq("rd_data", rd_data, e.data);
          check_eq("rd_perr", rd_perr, e.perr);
        end
      end
      h2 <= h1;
      h1 <= cur;
    end
  end

  task automatic step();
    @(negedge CK);
    #1;
  endtask

  task automatic send(input logic port, input logic we, input logic [AW-1:0] a,
                      input logic [35:0] d, input logic [3:0] be, output int lat);
    logic g;
    lat = 0;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
    end
    forever begin
      #1;
      g = port ? p1_gnt : p0_gnt;
      if (g) record(port, we, a, d, be);
      step();
      if (g) break;
      lat++;
      if (lat > 60) begin
        check_eq("gnt_timeout", 0, 1);
        break;
      end
    end
    if (port) p1_req = 1'b0;
    else      p0_req = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_A"}, A, 0);
    check_eq({tag, "_ctl"}, {nE1, E2, nE3, nW}, 4'b1011);
    check_eq({tag, "_nB"}, {nBd, nBc, nBb, nBa}, 4'hF);
    check_eq({tag, "_nG_zz"}, {nG, ZZ}, 2'b10);
    check_eq({tag, "_dq"}, {dq_oe, dq_o}, 0);
    check_eq({tag, "_rd"}, {rd_valid, rd_port, rd_perr, rd_data}, 0);
  endtask

  task automatic reset_and_check(input int cyc);
    nRST   = 1'b0;
    p0_req = 1'b1;
    p1_req = 1'b1;
    repeat (cyc) step();
    #1;
    check_eq("rst_gnt", {p0_gnt, p1_gnt}, 0);
    check_reset_outs("rst");
    p0_req = 1'b0;
    p1_req = 1'b0;
    nRST   = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, k;
    logic g;
    nRST = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_be = '0;

    reset_and_check(3);

    // Write then read back, pin timing
    send(0, 1, 21'h00010, 36'h123456789, 4'hF, lat);
    check_eq("wr_pins", {nE1, E2, nE3, nW}, 4'b0100);
    check_eq("wr_A", A, 21'h00010);
    check_eq("wr_nB", {nBd, nBc, nBb, nBa}, 4'h0);
    step();
    step();
    check_eq("wr_dq_oe", dq_oe, 1);
    check_eq("wr_dq_o", dq_o, par_fix(36'h123456789));
    send(0, 0, 21'h00010, 36'h0, 4'h0, lat);
    check_eq("rd_pins", {nE1, nW, nBd, nBc, nBb, nBa}, 6'b010000);
    drain();

    // Partial byte-enable write then read
    send(1, 1, 21'h00020, 36'hFEDCBA987, 4'b0101, lat);
    check_eq("be_pins", {nBd, nBc, nBb, nBa}, 4'b1010);
    send(1, 0, 21'h00020, 36'h0, 4'h0, lat);
    drain();

    // Back-to-back random read/write mix
    reset_and_check(2);
    for (int i = 0; i < 16; i++) begin
      send(1'(i % 2 == 1 && i > 8), 1'($urandom_range(0, 1)), AW'($urandom_range(64, 67)),
           36'({$urandom(), $urandom()}), 4'($urandom_range(0, 15)), lat);
      check_eq("b2b_lat", lat, 0);
    end
    drain();

    // Round-robin arbitration with both ports requesting
    reset_and_check(2);
    p0_req = 1; p0_we = 0; p0_addr = 21'h00010; p0_be = 0;
    p1_req = 1; p1_we = 0; p1_addr = 21'h00020; p1_be = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("arb_g0", p0_gnt, (i % 2) == 0);
      check_eq("arb_g1", p1_gnt, (i % 2) == 1);
      if (p0_gnt) record(0, 0, p0_addr, 36'h0, 4'h0);
      if (p1_gnt) record(1, 0, p1_addr, 36'h0, 4'h0);
      step();
      check_eq("arb_pins", {nE1, A}, {1'b0, (i % 2 == 0) ? 21'h00010 : 21'h00020});
    end
    p0_req = 0;
    p1_req = 0;
    drain();

    // Parity flip on byte 0 of read data
    flip_addr = 32'h30;
    send(0, 1, 21'h00030, 36'h1A5B6C7D8, 4'hF, lat);
    send(0, 0, 21'h00030, 36'h0, 4'h0, lat);
    drain();
    flip_addr = -1;

    // Reset one cycle after a read accept discards it
    send(0, 0, 21'h00010, 36'h0, 4'h0, lat);
    nRST = 1'b0;
    step();
    check_reset_outs("midrst");
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("midrst_quiet", {rd_valid, dq_oe}, 0);
    end

    // Idle sleep and wake
    reset_and_check(2);
    repeat (7) step();
    check_eq("zz_before", ZZ, 0);
    step();
    check_eq("zz_sleep", ZZ, 1);
    repeat (3) step();
    check_eq("zz_hold", ZZ, 1);
    p1_req = 1; p1_we = 0; p1_addr = 21'h00020; p1_be = 0;
    k = 0;
    g = 0;
    while (k < 50) begin
      #1;
      g = p1_gnt;
      if (k == 0) check_eq("zz_at_req", ZZ, 1);
      if (k == 1) check_eq("zz_wake", ZZ, 0);
      if (g) begin
        record(1, 0, p1_addr, 36'h0, 4'h0);
        break;
      end
      step();
      k++;
    end
    check_eq("wake_gnt", g, 1);
    check_eq("wake_lat", k, 5);
    step();
    p1_req = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
